// File: rtl/ex_muldiv.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO; 34-cycle result latency (2 for divide by zero).
// No queuing: start, mthi and mtlo are ignored while busy; flush aborts RUN/FIN without a commit.
module ex_muldiv (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        divZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        neg_r_q, neg_r_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;
  logic        divz_q, divz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_trial;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_nxt;
  logic [63:0] prod_fix;

  always_comb begin
    // Signed ops run on magnitudes; signs are reapplied at FIN.
    a_neg = ~op[0] & opA[31];
    b_neg = ~op[0] & opB[31];
    mag_a = a_neg ? (32'd0 - opA) : opA;
    mag_b = b_neg ? (32'd0 - opB) : opB;

    // acc = {partial product, remaining multiplier bits}
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_nxt = {mul_sum, acc_q[31:1]};

    // acc = {remainder, dividend bits / quotient bits}
    div_trial = acc_q[63:31];
    div_ge    = (div_trial >= {1'b0, b_q});
    div_diff  = div_trial[31:0] - b_q;
    div_nxt   = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    prod_fix  = neg_q ? (64'd0 - acc_q) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          acc_d    = {32'd0, mag_a};
          b_d      = mag_b;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          cnt_d    = 6'd0;
          dz_d     = op[1] && (opB == 32'd0);
          state_d  = (op[1] && (opB == 32'd0)) ? FIN : RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FIN;
        end
      end
      FIN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (!dz_q) begin
            if (is_div_q) begin
              lo_d = neg_q   ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
              hi_d = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end else begin
              hi_d = prod_fix[63:32];
              lo_d = prod_fix[31:0];
            end
          end
          done_d  = 1'b1;
          divz_d  = dz_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divZero = divz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed table-driven bench for ex_muldiv plus hand-written move, flush and reset sequences.
module tb_ex_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] opA, opB, wdata;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;

  vec_t vecs[10];

  ex_muldiv dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .opA(opA), .opB(opB),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Leaves the bench at the negedge one cycle after the launch edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    opA = $urandom;
    opB = $urandom;
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    int c;
    int bc;
    launch(o, a, b);
    c = 1;
    bc = 0;
    while (c < 100) begin
      if (done) break;
      if (busy) bc++;
      @(negedge CLK);
      c++;
    end
    chk({nm, " latency"}, 64'(c), edz ? 64'd2 : 64'd34);
    chk({nm, " busy cycles"}, 64'(bc), edz ? 64'd1 : 64'd33);
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " divZero"}, 64'(divZero), 64'(edz));
    @(negedge CLK);
    chk({nm, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int c;
    int ndone;

    vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[8] = '{MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};
    vecs[9] = '{MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

    RST = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; opA = 32'd0; opB = 32'd0; wdata = 32'd0;

    repeat (2) @(negedge CLK);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset divZero", 64'(divZero), 64'd0);
    RST = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].ehi, vecs[i].elo, vecs[i].edz);

    // Both moves in one cycle, then divide by zero must leave them intact.
    @(negedge CLK);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h00001234;
    @(negedge CLK);
    mthi = 1'b0; wdata = 32'h00005678;
    @(negedge CLK);
    mtlo = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    chk("mtlo", 64'(lo), 64'h5678);
    run_op("divu by zero", DIVU, 32'd5, 32'd0, 32'h00001234, 32'h00005678, 1'b1);

    // Start and mtlo while busy are ignored.
    launch(MULT, 32'd100, 32'hFFFFFFFE);
    repeat (4) @(negedge CLK);
    op = DIVU; opA = 32'd9; opB = 32'd3; start = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge CLK);
    start = 1'b0; mtlo = 1'b0;
    c = 6;
    while (c < 100 && !done) begin
      @(negedge CLK);
      c++;
    end
    chk("busy-ignore latency", 64'(c), 64'd34);
    chk("busy-ignore hi", 64'(hi), 64'hFFFFFFFF);
    chk("busy-ignore lo", 64'(lo), 64'hFFFFFF38);
    @(negedge CLK);
    if (!busy && !done) begin
      // A start issued now, in IDLE, is not queued from the earlier pulse.
      chk("no queued op busy", 64'(busy), 64'd0);
    end

    // Flush at cycle 10 of a second MULT.
    launch(MULT, 32'd3, 32'd5);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge CLK);
    end
    chk("flush no done", 64'(ndone), 64'd0);
    chk("flush hi", 64'(hi), 64'hFFFFFFFF);
    chk("flush lo", 64'(lo), 64'hFFFFFF38);

    // Asynchronous reset at cycle 20 of a DIV.
    launch(DIV, 32'd100, 32'd7);
    repeat (19) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mid reset hi", 64'(hi), 64'd0);
    chk("mid reset lo", 64'(lo), 64'd0);
    chk("mid reset busy", 64'(busy), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge CLK);
    end
    chk("post reset no done", 64'(ndone), 64'd0);

    run_op("recover divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
